// File: rtl/demux_4c_buf_pkg.sv
// demux_4c_buf_pkg: shared channel count, select width and channel indices for the 1:4 demux
package demux_4c_buf_pkg;
    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;
    localparam logic [SEL_W-1:0] CH0 = 2'd0;
    localparam logic [SEL_W-1:0] CH1 = 2'd1;
    localparam logic [SEL_W-1:0] CH2 = 2'd2;
    localparam logic [SEL_W-1:0] CH3 = 2'd3;
endpackage

// File: rtl/demux_4c_slot.sv
// demux_4c_slot: one-entry channel holding register with valid/ready drain
module demux_4c_slot
    import demux_4c_buf_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] dout
);
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;

    // a load wins over a drain, so a same-edge drain+refill keeps valid high
    always_comb begin
        valid_d = load | (valid_q & ~ready);
        data_d  = load ? din : data_q;
    end

    // holding register; reset discards any held word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign dout  = data_q;
endmodule

// File: rtl/demux_4c_buf.sv
// demux_4c_buf: registered 1:4 demultiplexer routing by sel or round-robin pointer
module demux_4c_buf
    import demux_4c_buf_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              auto,
    input  logic [1:0]        sel,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    output logic [3:0]        out_valid,
    input  logic [3:0]        out_ready,
    output logic [WIDTH-1:0]  out_data0,
    output logic [WIDTH-1:0]  out_data1,
    output logic [WIDTH-1:0]  out_data2,
    output logic [WIDTH-1:0]  out_data3,
    output logic [1:0]        ptr
);
    logic [SEL_W-1:0]  tgt, ptr_q, ptr_d;
    logic              accept;
    logic [NUM_CH-1:0] load;
    logic [WIDTH-1:0]  dout [NUM_CH];

    // target lane, handshake, one-hot load strobe and pointer advance
    always_comb begin
        tgt      = auto ? ptr_q : sel;
        in_ready = ~out_valid[tgt] | out_ready[tgt];
        accept   = in_valid & in_ready;
        load     = accept ? (NUM_CH'(1) << tgt) : '0;
        ptr_d    = (auto & accept) ? ptr_q + 1'b1 : ptr_q;
    end

    // round-robin pointer; only moves on an auto-mode accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_slot
        demux_4c_slot #(.WIDTH(WIDTH)) u_slot (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (load[g]),
            .din   (in_data),
            .ready (out_ready[g]),
            .valid (out_valid[g]),
            .dout  (dout[g])
        );
    end

    assign out_data0 = dout[CH0];
    assign out_data1 = dout[CH1];
    assign out_data2 = dout[CH2];
    assign out_data3 = dout[CH3];
    assign ptr       = ptr_q;
endmodule

// File: tb/tb_demux_4c_buf.sv
// tb_demux_4c_buf: scoreboard bench for the 1:4 valid/ready demux
module tb_demux_4c_buf;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       auto = 1'b0;
    logic [1:0] sel = 2'd0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'd0;
    logic [3:0] out_valid;
    logic [3:0] out_ready = 4'b1111;
    logic [7:0] out_data0, out_data1, out_data2, out_data3;
    logic [1:0] ptr;
    logic [7:0] od [4];

    int passed = 0;
    int total  = 0;
    logic [9:0] exp_q [$];

    demux_4c_buf #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .auto      (auto),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data0 (out_data0),
        .out_data1 (out_data1),
        .out_data2 (out_data2),
        .out_data3 (out_data3),
        .ptr       (ptr)
    );

    always #5 clk = ~clk;

    assign od[0] = out_data0;
    assign od[1] = out_data1;
    assign od[2] = out_data2;
    assign od[3] = out_data3;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // drive one word, wait (bounded) for in_ready, record the expected lane/data
    task automatic send(input logic [7:0] d, input logic a, input logic [1:0] s, input logic [1:0] lane);
        int n;
        n = 0;
        in_data = d;
        auto = a;
        sel = s;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) check("send_timeout", {31'd0, in_ready}, 32'd1);
        else exp_q.push_back({lane, d});
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // monitor: every output handshake pops the oldest expected word for that lane
    always @(negedge clk) begin
        int idx;
        if (rst_n) begin
            for (int k = 0; k < 4; k++) begin
                if (out_valid[k] && out_ready[k]) begin
                    idx = -1;
                    for (int i = 0; i < exp_q.size(); i++)
                        if (idx < 0 && exp_q[i][9:8] == k[1:0]) idx = i;
                    if (idx < 0) begin
                        total++;
                        $display("FAIL lane%0d_unexpected: got %0h expected no output", k, od[k]);
                    end else begin
                        check($sformatf("lane%0d_data", k), {24'd0, od[k]}, {24'd0, exp_q[idx][7:0]});
                        exp_q.delete(idx);
                    end
                end
            end
        end
    end

    initial begin
        #2;
        check("rst_out_valid", {28'd0, out_valid}, 32'h0);
        check("rst_ptr", {30'd0, ptr}, 32'h0);
        check("rst_in_ready", {31'd0, in_ready}, 32'h1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(1);

        // explicit routing
        send(8'hA1, 1'b0, 2'd3, 2'd3);
        check("expl_valid_a", {28'd0, out_valid}, 32'h8);
        check("expl_data3", {24'd0, out_data3}, 32'hA1);
        send(8'hB2, 1'b0, 2'd0, 2'd0);
        check("expl_valid_b", {28'd0, out_valid}, 32'h1);
        check("expl_data0", {24'd0, out_data0}, 32'hB2);
        idle(2);

        // round robin with wrap
        for (int i = 0; i < 5; i++) begin
            check($sformatf("rr_ptr_%0d", i), {30'd0, ptr}, i % 4);
            send(8'h10 + 8'(i), 1'b1, 2'd0, 2'(i % 4));
        end
        check("rr_ptr_end", {30'd0, ptr}, 32'h1);
        check("rr_data0", {24'd0, out_data0}, 32'h14);
        idle(2);

        // backpressure on lane 1 with same-edge drain+refill
        out_ready = 4'b1101;
        send(8'h55, 1'b0, 2'd1, 2'd1);
        in_data = 8'h66;
        sel = 2'd1;
        in_valid = 1'b1;
        @(negedge clk);
        check("bp_in_ready_low", {31'd0, in_ready}, 32'h0);
        @(posedge clk);
        #1;
        check("bp_held_data", {24'd0, out_data1}, 32'h55);
        out_ready = 4'b1111;
        @(negedge clk);
        check("bp_in_ready_high", {31'd0, in_ready}, 32'h1);
        if (in_ready) exp_q.push_back({2'd1, 8'h66});
        @(posedge clk);
        #1 in_valid = 1'b0;
        check("bp_valid_kept", {31'd0, out_valid[1]}, 32'h1);
        check("bp_new_data", {24'd0, out_data1}, 32'h66);
        idle(2);

        // auto stall on a full lane 1 while ptr=1
        out_ready = 4'b1101;
        send(8'h20, 1'b0, 2'd1, 2'd1);
        in_data = 8'h21;
        auto = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("stall_in_ready_%0d", i), {31'd0, in_ready}, 32'h0);
            check($sformatf("stall_ptr_%0d", i), {30'd0, ptr}, 32'h1);
            check($sformatf("stall_lane2_%0d", i), {31'd0, out_valid[2]}, 32'h0);
        end
        @(posedge clk);
        #1 out_ready = 4'b1111;
        @(negedge clk);
        check("stall_release", {31'd0, in_ready}, 32'h1);
        if (in_ready) exp_q.push_back({2'd1, 8'h21});
        @(posedge clk);
        #1 in_valid = 1'b0;
        check("stall_ptr_adv", {30'd0, ptr}, 32'h2);
        check("stall_valid", {28'd0, out_valid}, 32'h2);
        send(8'h22, 1'b1, 2'd0, 2'd2);
        check("stall_ptr_end", {30'd0, ptr}, 32'h3);
        idle(2);

        // independent drain of lanes 0 and 2 while lane 3 loads
        out_ready = 4'b0000;
        send(8'h30, 1'b0, 2'd0, 2'd0);
        send(8'h32, 1'b0, 2'd2, 2'd2);
        check("ind_before", {28'd0, out_valid}, 32'h5);
        in_data = 8'h33;
        sel = 2'd3;
        in_valid = 1'b1;
        out_ready = 4'b0101;
        @(negedge clk);
        check("ind_in_ready", {31'd0, in_ready}, 32'h1);
        if (in_ready) exp_q.push_back({2'd3, 8'h33});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 4'b0000;
        check("ind_after", {28'd0, out_valid}, 32'h8);
        out_ready = 4'b1111;
        idle(2);

        // asynchronous reset with lane 2 full and ptr nonzero
        out_ready = 4'b0000;
        send(8'h44, 1'b0, 2'd2, 2'd2);
        check("pre_rst_lane2", {31'd0, out_valid[2]}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", {28'd0, out_valid}, 32'h0);
        check("arst_ptr", {30'd0, ptr}, 32'h0);
        check("arst_data2", {24'd0, out_data2}, 32'h0);
        exp_q.delete();
        idle(1);
        rst_n = 1'b1;
        out_ready = 4'b1111;
        idle(3);

        check("scoreboard_empty", exp_q.size(), 32'h0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
